// File: rtl/jt12_slot_sched.sv
// Slot scheduler and channel-config controller for the FM accumulator stage.
// Walks the 24-slot operator timeline in the order S1, S3, S2, S4 (6 channels
// each) and serves the per-channel alg/rl/pcm_en of the slot being processed.
// CPU writes are parked in a single pending register and committed only at the
// 23->0 wrap, so a channel's config never changes in the middle of a sample.
//
// Write FSM:
//   state   | meaning
//   ST_IDLE | no write pending, a new cfg_wr can be accepted
//   ST_PEND | pending register holds a write waiting for the next wrap
module jt12_slot_sched #(
    parameter int         PIPE_DLY = 0,
    parameter logic [1:0] RL_RST   = 2'b11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       cfg_wr,
    input  logic [2:0] cfg_ch,
    input  logic [2:0] cfg_alg,
    input  logic [1:0] cfg_rl,
    input  logic       cfg_pcm_en,
    output logic       cfg_busy,
    output logic       cfg_ack,
    output logic       cfg_err,
    output logic [4:0] slot,
    output logic [2:0] cur_ch,
    output logic       s1_enters,
    output logic       s2_enters,
    output logic       s3_enters,
    output logic       s4_enters,
    output logic       ch6op,
    output logic [2:0] alg,
    output logic [1:0] rl,
    output logic       pcm_en,
    output logic       sample_tick
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } wr_state_t;

    localparam logic [5:0] CFG_RST_WORD = {3'd0, RL_RST, 1'b0};

    wr_state_t  wr_state;

    logic [2:0] pend_ch;
    logic [2:0] pend_alg;
    logic [1:0] pend_rl;
    logic       pend_pcm;

    logic [2:0] ch_alg [0:5];
    logic [1:0] ch_rl  [0:5];
    logic       ch_pcm [0:5];

    // {alg, rl, pcm_en}; the last stage drives the outputs directly
    logic [5:0] dly [0:PIPE_DLY];

    logic       wrap;
    logic       commit;
    logic       wr_ok;
    logic       wr_bad;
    logic [4:0] slot_nxt;
    logic [2:0] ch_nxt;
    logic [5:0] cfg_nxt;

    // Next-slot values and write/commit qualifiers
    always_comb begin
        wrap     = clk_en && (slot == 5'd23);
        commit   = wrap && (wr_state == ST_PEND);
        wr_ok    = cfg_wr && (wr_state == ST_IDLE) && (cfg_ch <= 3'd5);
        wr_bad   = cfg_wr && ((wr_state == ST_PEND) || (cfg_ch > 3'd5));
        slot_nxt = (slot == 5'd23) ? 5'd0 : slot + 5'd1;
        ch_nxt   = (cur_ch == 3'd5) ? 3'd0 : cur_ch + 3'd1;
    end

    // Config of the channel entering next; a write committing on this same
    // edge is forwarded so it shows up starting at slot 0
    always_comb begin
        cfg_nxt = {ch_alg[ch_nxt], ch_rl[ch_nxt], ch_pcm[ch_nxt]};
        if (commit && (pend_ch == ch_nxt)) begin
            cfg_nxt = {pend_alg, pend_rl, pend_pcm};
        end
    end

    // Slot timeline: counter, channel, group flags and the sample pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            slot        <= 5'd0;
            cur_ch      <= 3'd0;
            s1_enters   <= 1'b1;
            s2_enters   <= 1'b0;
            s3_enters   <= 1'b0;
            s4_enters   <= 1'b0;
            ch6op       <= 1'b0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= wrap;
            if (clk_en) begin
                slot      <= slot_nxt;
                cur_ch    <= ch_nxt;
                ch6op     <= (ch_nxt == 3'd5);
                s1_enters <= (slot_nxt < 5'd6);
                s3_enters <= (slot_nxt >= 5'd6)  && (slot_nxt < 5'd12);
                s2_enters <= (slot_nxt >= 5'd12) && (slot_nxt < 5'd18);
                s4_enters <= (slot_nxt >= 5'd18);
            end
        end
    end

    // Write FSM: accept into pending, reject when busy or channel invalid,
    // release on the wrap edge
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= ST_IDLE;
            cfg_busy <= 1'b0;
            cfg_ack  <= 1'b0;
            cfg_err  <= 1'b0;
            pend_ch  <= 3'd0;
            pend_alg <= 3'd0;
            pend_rl  <= 2'd0;
            pend_pcm <= 1'b0;
        end else begin
            cfg_ack <= 1'b0;
            cfg_err <= wr_bad;
            case (wr_state)
                ST_IDLE: begin
                    if (wr_ok) begin
                        pend_ch  <= cfg_ch;
                        pend_alg <= cfg_alg;
                        pend_rl  <= cfg_rl;
                        pend_pcm <= (cfg_ch == 3'd5) ? cfg_pcm_en : 1'b0;
                        wr_state <= ST_PEND;
                        cfg_busy <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (commit) begin
                        wr_state <= ST_IDLE;
                        cfg_busy <= 1'b0;
                        cfg_ack  <= 1'b1;
                    end
                end
                default: begin
                    wr_state <= ST_IDLE;
                    cfg_busy <= 1'b0;
                end
            endcase
        end
    end

    // Per-channel config storage, written only by a commit
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) begin
                ch_alg[i] <= 3'd0;
                ch_rl[i]  <= RL_RST;
                ch_pcm[i] <= 1'b0;
            end
        end else if (commit) begin
            ch_alg[pend_ch] <= pend_alg;
            ch_rl[pend_ch]  <= pend_rl;
            ch_pcm[pend_ch] <= pend_pcm;
        end
    end

    // Config delay line to line up with the operator pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= PIPE_DLY; i++) begin
                dly[i] <= CFG_RST_WORD;
            end
        end else if (clk_en) begin
            dly[0] <= cfg_nxt;
            for (int i = 1; i <= PIPE_DLY; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign alg    = dly[PIPE_DLY][5:3];
    assign rl     = dly[PIPE_DLY][2:1];
    assign pcm_en = dly[PIPE_DLY][0];

endmodule
